// File: rtl/soundrive_pkg.sv
// Shared constants for the Soundrive playback block: channel indices, frame lanes.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package soundrive_pkg;

  localparam int FRAME_W = 32;

  // Channel register indices (A/B feed the left mix, C/D the right).
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // Byte lanes within a 32-bit frame; lane 0 sits in bits [7:0].
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Pick one byte lane out of a frame.
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                            input logic [1:0]         lane);
    logic [7:0] b;
    case (lane)
      LANE_0:  b = frame[7:0];
      LANE_1:  b = frame[15:8];
      LANE_2:  b = frame[23:16];
      default: b = frame[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/soundrive_fifo.sv
// Synchronous frame FIFO with first-word-fall-through head and flush.
// Latency: a pushed frame appears at the head on the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; flush wins over both.
module soundrive_fifo
  import soundrive_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [FRAME_W-1:0]       push_dat_i,
  input  logic                     pop_i,
  output logic [FRAME_W-1:0]       head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;

  // Pointer next-state: the extra top bit distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == FULL_LVL);

endmodule

// File: rtl/soundrive_player.sv
// Soundrive DAC playback scheduler: buffers frames, releases them on a period tick, merges CPU writes.
// Latency: channel registers update on the edge after a tick or CPU write (1 cycle).
// Backpressure: s_ready drops when the FIFO is full or playback is disabled; dma_req asks for refills.
module soundrive_player
  import soundrive_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int LOW_WM = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_en,
  input  logic                   cfg_mono,
  input  logic [15:0]            cfg_div,
  input  logic                   cpu_wr,
  input  logic [1:0]             cpu_ch,
  input  logic [7:0]             cpu_di,
  input  logic                   s_valid,
  input  logic [FRAME_W-1:0]     s_data,
  output logic                   s_ready,
  output logic                   dma_req,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun,
  output logic [7:0]             outa,
  output logic [7:0]             outb,
  output logic [7:0]             outc,
  output logic [7:0]             outd
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [15:0]        cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic               mono_q;
  logic [3:0][7:0]    ch_q, ch_d;

  logic [FRAME_W-1:0] head;
  logic               full, empty;
  logic               push, pop, tick, play, mono_chg;
  logic [1:0]         idx_cur;

  // Disabling playback flushes the buffer; frames offered then are refused.
  assign s_ready  = cfg_en && !full;
  assign push     = s_valid && s_ready;
  assign dma_req  = cfg_en && (fifo_level <= LW'(LOW_WM));

  assign tick     = cfg_en && (cnt_q == 16'd0);
  assign play     = tick && !empty;
  assign underrun = tick && empty;

  // A mode switch restarts byte stepping at lane 0 of the current head frame.
  assign mono_chg = (cfg_mono != mono_q);
  assign idx_cur  = mono_chg ? LANE_0 : idx_q;
  assign pop      = play && (!cfg_mono || (idx_cur == LANE_3));

  soundrive_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (!cfg_en),
    .push_i     (push),
    .push_dat_i (s_data),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (fifo_level)
  );

  // Period counter and mono byte index next-state; both restart while disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_cur;
    if (!cfg_en) begin
      cnt_d = cfg_div;
      idx_d = LANE_0;
    end else begin
      cnt_d = (cnt_q == 16'd0) ? cfg_div : cnt_q - 16'd1;
      if (play && cfg_mono) idx_d = idx_cur + 2'd1;
    end
  end

  // Channel merge: DMA value on a playing tick, then a CPU write overrides its one channel.
  always_comb begin
    ch_d = ch_q;
    if (play) begin
      for (int i = 0; i < 4; i++) begin
        ch_d[i] = cfg_mono ? frame_byte(head, idx_cur) : frame_byte(head, 2'(i));
      end
    end
    if (cpu_wr) ch_d[cpu_ch] = cpu_di;
  end

  // State registers; counter reloads from cfg_div on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= cfg_div;
      idx_q  <= LANE_0;
      mono_q <= cfg_mono;
      ch_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      mono_q <= cfg_mono;
      ch_q   <= ch_d;
    end
  end

  assign outa = ch_q[CH_A];
  assign outb = ch_q[CH_B];
  assign outc = ch_q[CH_C];
  assign outd = ch_q[CH_D];

endmodule

// File: tb/tb_soundrive_player.sv
// Directed bench for soundrive_player: stereo/mono playback, FIFO fill, streaming, CPU merge, disable.
// Latency: inputs driven just after negedge, outputs sampled before the next posedge.
// Backpressure: s_ready/dma_req checked against hand-computed expectations.
module tb_soundrive_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en;
  logic        cfg_mono;
  logic [15:0] cfg_div;
  logic        cpu_wr;
  logic [1:0]  cpu_ch;
  logic [7:0]  cpu_di;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        dma_req;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic [7:0]  outa, outb, outc, outd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  soundrive_player #(.DEPTH(8), .LOW_WM(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_en     (cfg_en),
    .cfg_mono   (cfg_mono),
    .cfg_div    (cfg_div),
    .cpu_wr     (cpu_wr),
    .cpu_ch     (cpu_ch),
    .cpu_di     (cpu_di),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .dma_req    (dma_req),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .outa       (outa),
    .outb       (outb),
    .outc       (outc),
    .outd       (outd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] fk(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {8'hA0 + kb, 8'hB0 + kb, 8'hC0 + kb, 8'hD0 + kb};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cfg_en = 1'b0; cfg_mono = 1'b0; cfg_div = 16'd3;
    cpu_wr = 1'b0; cpu_ch = 2'd0; cpu_di = 8'h00; s_valid = 1'b0; s_data = '0;

    // ---------------- reset state ----------------
    repeat (3) cyc();
    chk("rst_outa", {24'd0, outa}, 32'h00);
    chk("rst_outd", {24'd0, outd}, 32'h00);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_dma_req", {31'd0, dma_req}, 32'd0);

    // ---------------- 1: stereo frame, cfg_div=3 ----------------
    reset = 1'b0; cfg_en = 1'b1; s_valid = 1'b1; s_data = 32'h44332211; #1;
    chk("t1_s_ready", {31'd0, s_ready}, 32'd1);
    chk("t1_dma_req", {31'd0, dma_req}, 32'd1);
    cyc(); s_valid = 1'b0; #1;
    chk("t1_level1", {28'd0, fifo_level}, 32'd1);
    chk("t1_outa_pre", {24'd0, outa}, 32'h00);
    cyc();
    cyc();
    chk("t1_no_underrun", {31'd0, underrun}, 32'd0);
    chk("t1_outa_tick", {24'd0, outa}, 32'h00);
    cyc();
    chk("t1_outa", {24'd0, outa}, 32'h11);
    chk("t1_outb", {24'd0, outb}, 32'h22);
    chk("t1_outc", {24'd0, outc}, 32'h33);
    chk("t1_outd", {24'd0, outd}, 32'h44);
    chk("t1_level0", {28'd0, fifo_level}, 32'd0);
    cyc();
    cyc();
    chk("t1_underrun_early", {31'd0, underrun}, 32'd0);
    cyc();
    chk("t1_underrun", {31'd0, underrun}, 32'd1);
    cyc();
    chk("t1_underrun_pulse", {31'd0, underrun}, 32'd0);
    chk("t1_hold_outa", {24'd0, outa}, 32'h11);

    // ---------------- 2: mono stream, cfg_div=0 ----------------
    cfg_en = 1'b0; cfg_mono = 1'b1; cfg_div = 16'd0;
    cyc();
    cfg_en = 1'b1; s_valid = 1'b1; s_data = 32'hDDCCBBAA; #1;
    chk("t2_underrun_first", {31'd0, underrun}, 32'd1);
    cyc(); s_valid = 1'b0; #1;
    chk("t2_level1", {28'd0, fifo_level}, 32'd1);
    chk("t2_no_underrun", {31'd0, underrun}, 32'd0);
    cyc();
    chk("t2_outa_AA", {24'd0, outa}, 32'hAA);
    chk("t2_outd_AA", {24'd0, outd}, 32'hAA);
    chk("t2_level_hold", {28'd0, fifo_level}, 32'd1);
    cyc();
    chk("t2_outb_BB", {24'd0, outb}, 32'hBB);
    cyc();
    chk("t2_outc_CC", {24'd0, outc}, 32'hCC);
    cyc();
    chk("t2_outa_DD", {24'd0, outa}, 32'hDD);
    chk("t2_outd_DD", {24'd0, outd}, 32'hDD);
    chk("t2_level0", {28'd0, fifo_level}, 32'd0);
    chk("t2_underrun", {31'd0, underrun}, 32'd1);

    // ---------------- 3: fill to full, stall, release ----------------
    cfg_en = 1'b0; cfg_mono = 1'b0; cfg_div = 16'd15;
    cyc();
    cfg_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 32'h0A0B0C00 + 32'(i); #1;
      chk("t3_fill_ready", {31'd0, s_ready}, 32'd1);
      chk("t3_fill_dma", {31'd0, dma_req}, (i <= 2) ? 32'd1 : 32'd0);
      chk("t3_fill_level", {28'd0, fifo_level}, 32'(i));
      cyc();
    end
    s_data = 32'h0A0B0C08; #1;
    chk("t3_full_level", {28'd0, fifo_level}, 32'd8);
    chk("t3_full_ready", {31'd0, s_ready}, 32'd0);
    chk("t3_full_dma", {31'd0, dma_req}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t3_stall_level", {28'd0, fifo_level}, 32'd8);
      chk("t3_stall_ready", {31'd0, s_ready}, 32'd0);
    end
    cyc();
    chk("t3_pop_level", {28'd0, fifo_level}, 32'd7);
    chk("t3_pop_ready", {31'd0, s_ready}, 32'd1);
    chk("t3_pop_outb", {24'd0, outb}, 32'h0C);
    chk("t3_pop_outd", {24'd0, outd}, 32'h0A);
    chk("t3_pop_dma", {31'd0, dma_req}, 32'd0);
    cyc(); s_valid = 1'b0; #1;
    chk("t3_refill_level", {28'd0, fifo_level}, 32'd8);

    // ---------------- 4: streaming at level 4, tick every cycle ----------------
    cfg_en = 1'b0; cfg_div = 16'd4;
    cyc();
    cfg_en = 1'b1; cfg_div = 16'd0;
    for (int k = 0; k < 17; k++) begin
      s_valid = (k < 12); s_data = fk(k); #1;
      if (k >= 5) begin
        chk("t4_outa_seq", {24'd0, outa}, {24'd0, 8'hD0 + 8'(k - 5)});
        chk("t4_outd_seq", {24'd0, outd}, {24'd0, 8'hA0 + 8'(k - 5)});
      end
      chk("t4_level", {28'd0, fifo_level},
          (k < 4) ? 32'(k) : ((k <= 12) ? 32'd4 : 32'(16 - k)));
      cyc();
    end

    // ---------------- 5: tick collides with CPU write to B ----------------
    s_valid = 1'b1; s_data = 32'h04030201; #1;
    chk("t4_drain_underrun", {31'd0, underrun}, 32'd1);
    cyc();
    s_valid = 1'b0; cpu_wr = 1'b1; cpu_ch = 2'd1; cpu_di = 8'h7F; #1;
    chk("t5_level1", {28'd0, fifo_level}, 32'd1);
    cyc();
    cpu_wr = 1'b0; #1;
    chk("t5_outa", {24'd0, outa}, 32'h01);
    chk("t5_outb", {24'd0, outb}, 32'h7F);
    chk("t5_outc", {24'd0, outc}, 32'h03);
    chk("t5_outd", {24'd0, outd}, 32'h04);
    chk("t5_level0", {28'd0, fifo_level}, 32'd0);

    // ---------------- 6: disable mid-playback, CPU write, re-enable ----------------
    cfg_en = 1'b0; cfg_div = 16'd7;
    cyc();
    cfg_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'h11110000 + 32'(i);
      cyc();
    end
    cfg_en = 1'b0; cfg_div = 16'd2; s_data = 32'hEEEEEEEE; #1;
    chk("t6_level5", {28'd0, fifo_level}, 32'd5);
    chk("t6_off_ready", {31'd0, s_ready}, 32'd0);
    chk("t6_off_dma", {31'd0, dma_req}, 32'd0);
    cyc();
    chk("t6_flush_level", {28'd0, fifo_level}, 32'd0);
    chk("t6_hold_outa", {24'd0, outa}, 32'h01);
    chk("t6_hold_outb", {24'd0, outb}, 32'h7F);
    s_valid = 1'b0; cpu_wr = 1'b1; cpu_ch = 2'd3; cpu_di = 8'h80;
    cyc();
    cpu_wr = 1'b0; #1;
    chk("t6_cpu_outd", {24'd0, outd}, 32'h80);
    chk("t6_cpu_outa", {24'd0, outa}, 32'h01);
    chk("t6_dropped_level", {28'd0, fifo_level}, 32'd0);
    cfg_en = 1'b1; s_valid = 1'b1; s_data = 32'h88776655; #1;
    chk("t6_reen_ready", {31'd0, s_ready}, 32'd1);
    cyc(); s_valid = 1'b0; #1;
    cyc();
    chk("t6_tick_outa_pre", {24'd0, outa}, 32'h01);
    chk("t6_tick_underrun", {31'd0, underrun}, 32'd0);
    cyc();
    chk("t6_reen_outa", {24'd0, outa}, 32'h55);
    chk("t6_reen_outd", {24'd0, outd}, 32'h88);
    chk("t6_reen_level", {28'd0, fifo_level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
